// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: one-word holding buffer feeding a WIDTH-bit shifter, MSB or LSB first.
// First bit appears two edges after acceptance; in_ready = ~hold_vld; macro SER_PARITY_EN appends an even-parity bit.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_done_q, frame_done_d;
    logic             load_next;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_vld_d    = hold_vld_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        load_next     = 1'b0;
`ifdef SER_PARITY_EN
        par_d         = par_q;
`endif

        if (in_valid && !hold_vld_q) begin
            hold_d     = in_data;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: load_next = hold_vld_q;
            SHIFT: begin
                if (cnt_q != LAST_BIT) begin
                    ser_out_d   = head_bit(shift_q);
                    shift_d     = advance(shift_q);
                    cnt_d       = cnt_q + CNT_W'(1);
                    ser_valid_d = 1'b1;
`ifdef SER_PARITY_EN
                    frame_done_d = 1'b0;
`else
                    frame_done_d = (cnt_q == LAST_BIT - CNT_W'(1));
`endif
                end else begin
`ifdef SER_PARITY_EN
                    state_d      = PAR;
                    ser_out_d    = par_q;
                    ser_valid_d  = 1'b1;
                    frame_done_d = 1'b1;
`else
                    state_d      = IDLE;
                    load_next    = hold_vld_q;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                state_d   = IDLE;
                load_next = hold_vld_q;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Bit 0 is registered straight from hold so back-to-back frames have no bubble.
        if (load_next) begin
            state_d       = SHIFT;
            hold_vld_d    = 1'b0;
            ser_out_d     = head_bit(hold_q);
            shift_d       = advance(hold_q);
            cnt_d         = '0;
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
            frame_done_d  = 1'b0;
`ifdef SER_PARITY_EN
            par_d         = ^hold_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            hold_vld_q    <= 1'b0;
            shift_q       <= '0;
            cnt_q         <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef SER_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_vld_q    <= hold_vld_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
`ifdef SER_PARITY_EN
            par_q         <= par_d;
`endif
        end
    end

    assign in_ready    = ~hold_vld_q;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus; a scoreboard
// queue per instance holds {bit, frame_start, frame_done} per expected serial cycle.
module tb_piso_serializer;

`ifdef SER_PARITY_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;

    logic in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_done_m;
    logic in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_done_l;

    int checks = 0;
    int errors = 0;
    logic [2:0] q_m[$];
    logic [2:0] q_l[$];
    int run_len  = 0;
    int last_run = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
        .frame_start(frame_start_m), .frame_done(frame_done_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
        .frame_start(frame_start_l), .frame_done(frame_done_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected serial cycles for one 8-bit word on both instances.
    task automatic push_frame(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            logic s, d;
            s = (i == 0);
            d = (i == 7) && (FRAME_LEN == 8);
            q_m.push_back({w[7-i], s, d});
            q_l.push_back({w[i], s, d});
        end
        if (FRAME_LEN == 9) begin
            q_m.push_back({^w, 1'b0, 1'b1});
            q_l.push_back({^w, 1'b0, 1'b1});
        end
    endtask

    // Present w until accepted; waits = negedges seen with in_ready low.
    task automatic send(input logic [7:0] w, output int waits);
        waits    = 0;
        in_data  = w;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready_m && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready_m) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 for word %0h", w);
        end
        @(posedge clk);
        #1;
        push_frame(w);
        in_valid = 1'b0;
        in_data  = ~w;
    endtask

    task automatic wait_idle(input string name, input int exp_run);
        int n = 0;
        @(negedge clk);
        while (!ser_valid_m && n < 200) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (ser_valid_m && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (ser_valid_m || n == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: frame never started or never ended", name);
        end
        @(posedge clk);
        #1;
        check(name, last_run, exp_run);
    endtask

    always @(negedge clk) begin
        logic [2:0] e;
        if (ser_valid_m) begin
            run_len++;
            if (q_m.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL msb_unexpected_bit: got bit %0b, expected no frame", ser_out_m);
            end else begin
                e = q_m.pop_front();
                check("msb_bit_start_done", {29'd0, ser_out_m, frame_start_m, frame_done_m}, {29'd0, e});
            end
        end else begin
            if (run_len > 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            check("msb_idle_outputs", {29'd0, ser_out_m, frame_start_m, frame_done_m}, 32'd0);
        end
        if (ser_valid_l) begin
            if (q_l.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lsb_unexpected_bit: got bit %0b, expected no frame", ser_out_l);
            end else begin
                e = q_l.pop_front();
                check("lsb_bit_start_done", {29'd0, ser_out_l, frame_start_l, frame_done_l}, {29'd0, e});
            end
        end else begin
            check("lsb_idle_outputs", {29'd0, ser_out_l, frame_start_l, frame_done_l}, 32'd0);
        end
    end

    initial begin
        int w;

        // Reset with in_valid high: the word must not be accepted.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready_m}, 32'd1);
        check("reset_ser_valid", {31'd0, ser_valid_m}, 32'd0);
        check("reset_in_ready_lsb", {31'd0, in_ready_l}, 32'd1);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 8'hB5 MSB first: 1,0,1,1,0,1,0,1 (parity of five ones = 1); bit 0 after E1.
        send(8'hB5, w);
        check("accept_wait_empty", w, 0);
        check("hold_full_in_ready", {31'd0, in_ready_m}, 32'd0);
        @(negedge clk);
        check("latency_no_bit_before_e1", {31'd0, ser_valid_m}, 32'd0);
        @(negedge clk);
        check("latency_first_bit", {29'd0, ser_valid_m, frame_start_m, ser_out_m}, 32'd7);
        wait_idle("single_frame_len", FRAME_LEN);
        check("idle_in_ready", {31'd0, in_ready_m}, 32'd1);

        // Back-to-back with a stall: the third word waits until hold empties at frame 2 start.
        send(8'hB0, w);
        send(8'h0D, w);
        check("b2b_second_wait", w, 1);
        send(8'h5A, w);
        check("stall_third_wait", w, FRAME_LEN - 1);
        wait_idle("b2b_run_len", 3 * FRAME_LEN);

        // Reset on the third bit of a frame with a second word held.
        send(8'hA5, w);
        send(8'h3C, w);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        @(posedge clk);
        #1;
        check("abort_ser_valid", {31'd0, ser_valid_m}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready_m}, 32'd1);
        check("abort_no_done", {31'd0, frame_done_m}, 32'd0);
        q_m.delete();
        q_l.delete();
        reset    = 1'b0;
        in_valid = 1'b0;

        send(8'hFF, w);
        wait_idle("post_reset_frame", FRAME_LEN);

        // 8'h01: LSB-first instance emits 1,0,0,0,0,0,0,0.
        send(8'h01, w);
        wait_idle("lsb_frame_len", FRAME_LEN);

        repeat (4) @(posedge clk);
        #1;
        check("msb_queue_drained", q_m.size(), 0);
        check("lsb_queue_drained", q_l.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
